// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states and instruction/PC constants.
package cpu_pkg;
   typedef enum logic [1:0] {REQ, WAIT, KILL} fetch_state_t;
   localparam int INSTR_W = 32;
   localparam int PC_STEP = 4;
endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, single-outstanding imem read, and a
// one-entry output register toward decode; redirects squash in-flight fetches.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [INSTR_W-1:0] id_instr,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [ADDR_W-1:0]  id_pc_plus4
);

   fetch_state_t       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic               out_valid_q, out_valid_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  opc_q, opc_d;
   logic               req_want;
   logic               req_fire;
   logic [ADDR_W-1:0]  target;

   // Gated with rst_n so no request is presented while reset is held.
   assign imem_req_valid = req_want && rst_n;
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign target         = redirect_pc & ~ADDR_W'(3);

   assign id_valid    = out_valid_q;
   assign id_instr    = instr_q;
   assign id_pc       = opc_q;
   assign id_pc_plus4 = opc_q + ADDR_W'(PC_STEP);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      instr_d     = instr_q;
      opc_d       = opc_q;
      req_want    = 1'b0;

      if (out_valid_q && id_ready) out_valid_d = 1'b0;

      case (state_q)
         REQ: begin
            req_want = !out_valid_q || id_ready;
            if (req_fire) state_d = WAIT;
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               state_d = REQ;
               if (!redirect_valid) begin
                  out_valid_d = 1'b1;
                  instr_d     = imem_rsp_data;
                  opc_d       = pc_q;
                  pc_d        = pc_q + ADDR_W'(PC_STEP);
               end
            end
         end
         KILL: begin
            if (imem_rsp_valid) state_d = REQ;
         end
         default: state_d = REQ;
      endcase

      // A redirect wins over everything; anything in flight must be discarded.
      if (redirect_valid) begin
         pc_d        = target;
         out_valid_d = 1'b0;
         case (state_q)
            REQ:     state_d = req_fire ? KILL : REQ;
            WAIT:    state_d = imem_rsp_valid ? REQ : KILL;
            KILL:    state_d = imem_rsp_valid ? REQ : KILL;
            default: state_d = REQ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= REQ;
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         instr_q     <= '0;
         opc_q       <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         instr_q     <= instr_d;
         opc_q       <= opc_d;
      end
   end

endmodule
